// File: rtl/header_seq.sv
// Packet-header sequencer: after the access code, opens the header and HEC bit windows,
// drives the FEC1/3 bit-advance strobe and payload start, then grades the received HEC.
module header_seq #(
  parameter int HDR_BITS = 10,
  parameter int HEC_BITS = 8,
  parameter int FEC_REP  = 3
) (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       p_1us,
  input  logic       start_p,
  input  logic       pk_encode,
  input  logic       abort,
  input  logic [7:0] hecrem,
  output logic       header_st_p,
  output logic       header_en,
  output logic       hec_en,
  output logic       fec31inc_p,
  output logic       py_st_p,
  output logic       hdr_done_p,
  output logic       hec_good,
  output logic       busy,
  output logic [4:0] bitcnt
);

  localparam int NBITS = HDR_BITS + HEC_BITS;
  localparam int CW    = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam int RW    = $clog2(FEC_REP);
  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_BITS - 1);
  localparam logic [CW-1:0] ALL_LAST = CW'(NBITS - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(FEC_REP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, HEC, PYST, CHK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep;
  logic          mode;
  logic          in_win;

  assign in_win = (state == HDR) || (state == HEC);
  assign bitcnt = 5'(cnt);

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rep      <= '0;
      mode     <= 1'b0;
      hec_good <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_p && !abort)
        mode <= pk_encode;
      // Counters only run inside the bit windows; a strobe during LOAD is dropped.
      if (abort || state == IDLE || state == LOAD) begin
        cnt <= '0;
        rep <= '0;
      end else if (in_win && p_1us) begin
        if (rep != REP_LAST) begin
          rep <= rep + RW'(1);
        end else begin
          rep <= '0;
          if (cnt != ALL_LAST)
            cnt <= cnt + CW'(1);
        end
      end
      if (state == CHK && !mode && !abort)
        hec_good <= (hecrem == 8'h00);
    end
  end

  always_comb begin
    state_nxt   = state;
    header_st_p = 1'b0;
    header_en   = 1'b0;
    hec_en      = 1'b0;
    fec31inc_p  = 1'b0;
    py_st_p     = 1'b0;
    hdr_done_p  = 1'b0;
    busy        = (state != IDLE);
    if (in_win && p_1us && rep == REP_LAST)
      fec31inc_p = 1'b1;
    case (state)
      IDLE: if (start_p) state_nxt = LOAD;
      LOAD: begin
        header_st_p = 1'b1;
        state_nxt   = HDR;
      end
      HDR: begin
        header_en = 1'b1;
        if (fec31inc_p && cnt == HDR_LAST) state_nxt = HEC;
      end
      HEC: begin
        hec_en = 1'b1;
        if (fec31inc_p && cnt == ALL_LAST) state_nxt = PYST;
      end
      PYST: begin
        py_st_p   = 1'b1;
        state_nxt = CHK;
      end
      CHK: begin
        hdr_done_p = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort)
      state_nxt = IDLE;
  end

endmodule

// File: tb/tb_header_seq.sv
// Randomized bench for header_seq: per-cycle comparison against a strobe-counting packet model.
module tb_header_seq;

  localparam int HB   = 10;
  localparam int EB   = 8;
  localparam int R    = 3;
  localparam int TOT  = R * (HB + EB);
  localparam int LAST = HB + EB - 1;

  logic       clk_6M = 1'b0;
  logic       rst = 1'b1;
  logic       p_1us = 1'b0;
  logic       start_p = 1'b0;
  logic       pk_encode = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] hecrem = 8'h00;
  logic       header_st_p, header_en, hec_en, fec31inc_p, py_st_p, hdr_done_p, hec_good, busy;
  logic [4:0] bitcnt;

  header_seq dut (
    .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .start_p(start_p), .pk_encode(pk_encode),
    .abort(abort), .hecrem(hecrem), .header_st_p(header_st_p), .header_en(header_en),
    .hec_en(hec_en), .fec31inc_p(fec31inc_p), .py_st_p(py_st_p), .hdr_done_p(hdr_done_p),
    .hec_good(hec_good), .busy(busy), .bitcnt(bitcnt)
  );

  always #5 clk_6M = ~clk_6M;

  int n_chk = 0;
  int n_bad = 0;

  // Packet model: phase 0 idle, 1 seed load, 2 counting strobes, 3 payload start, 4 result.
  int m_ph = 0;
  int m_n  = 0;
  bit m_mode = 1'b0;
  bit m_hg = 1'b0;
  bit m_after = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input bit p);
    int bc;
    if (m_ph == 2)                          bc = m_n / R;
    else if (m_ph >= 3 || (m_ph == 0 && m_after)) bc = LAST;
    else                                    bc = 0;
    chk("header_st_p", int'(header_st_p), int'(m_ph == 1));
    chk("header_en",   int'(header_en),   int'(m_ph == 2 && m_n < R * HB));
    chk("hec_en",      int'(hec_en),      int'(m_ph == 2 && m_n >= R * HB));
    chk("fec31inc_p",  int'(fec31inc_p),  int'(m_ph == 2 && p && (m_n % R) == R - 1));
    chk("py_st_p",     int'(py_st_p),     int'(m_ph == 3));
    chk("hdr_done_p",  int'(hdr_done_p),  int'(m_ph == 4));
    chk("busy",        int'(busy),        int'(m_ph != 0));
    chk("hec_good",    int'(hec_good),    int'(m_hg));
    chk("bitcnt",      int'(bitcnt),      bc);
  endtask

  task automatic cyc(input bit p, input bit s, input bit enc, input bit ab, input logic [7:0] hr);
    @(negedge clk_6M);
    p_1us = p; start_p = s; pk_encode = enc; abort = ab; hecrem = hr;
    #1;
    check_outs(p);
    if (ab) begin
      m_ph = 0; m_after = 1'b0;
    end else begin
      case (m_ph)
        0: begin
          m_after = 1'b0;
          if (s) begin m_ph = 1; m_mode = enc; end
        end
        1: begin m_ph = 2; m_n = 0; end
        2: if (p) begin
          m_n++;
          if (m_n == TOT) m_ph = 3;
        end
        3: m_ph = 4;
        default: begin
          if (!m_mode) m_hg = (hr == 8'h00);
          m_ph = 0; m_after = 1'b1;
        end
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk_6M);
    p_1us = 1'b0; start_p = 1'b0; abort = 1'b0;
    #3 rst = 1'b1;
    #1;
    m_ph = 0; m_n = 0; m_hg = 1'b0; m_after = 1'b0;
    check_outs(1'b0);
    @(negedge clk_6M);
    #1 check_outs(1'b0);
    rst = 1'b0;
  endtask

  // pat: 0 = strobe every 6 clks, 1 = strobe every clk, 2 = random strobes.
  task automatic run_pkt(input bit enc, input int pat, input logic [7:0] hr,
                         input int ab_at, input bit spur, input int rst_at);
    bit done, aborted, spurred, p, s, ab;
    done = 1'b0; aborted = 1'b0; spurred = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (pat == 0)      p = (i % 6 == 5);
      else if (pat == 1) p = 1'b1;
      else               p = ($urandom_range(0, 3) == 0);
      s  = (i == 0);
      ab = 1'b0;
      if (m_ph == 2 && spur && !spurred && m_n == 7) begin s = 1'b1; spurred = 1'b1; end
      if (m_ph == 2 && ab_at >= 0 && !aborted && m_n / R == ab_at) begin ab = 1'b1; aborted = 1'b1; end
      if (m_ph == 2 && rst_at >= 0 && m_n / R == rst_at) begin
        do_reset();
        done = 1'b1;
      end else begin
        cyc(p, s, enc, ab, hr);
        if (m_ph == 0) done = 1'b1;
      end
    end
    chk("pkt_finished", int'(done), 1);
    for (int k = 0; k < 4; k++)
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, hr);
  endtask

  initial begin
    #12;
    check_outs(1'b0);
    @(negedge clk_6M);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    run_pkt(1'b1, 0, 8'h33, -1, 1'b0, -1);   // encode, strobe every 6 clks
    run_pkt(1'b0, 0, 8'h00, -1, 1'b0, -1);   // decode, good HEC
    run_pkt(1'b0, 0, 8'h5A, -1, 1'b0, -1);   // decode, bad HEC
    run_pkt(1'b0, 2, 8'h00, -1, 1'b0, -1);
    run_pkt(1'b0, 0, 8'h5A, 12, 1'b0, -1);   // abort in HEC window keeps hec_good
    run_pkt(1'b1, 0, 8'h5A, -1, 1'b0, -1);
    run_pkt(1'b1, 0, 8'h00, -1, 1'b1, -1);   // stray start_p while in HDR
    run_pkt(1'b0, 2, 8'h00, -1, 1'b0, 5);    // reset mid-header
    run_pkt(1'b1, 1, 8'h00, -1, 1'b0, -1);   // strobe on every clk, including LOAD
    run_pkt(1'b0, 1, 8'h00, -1, 1'b0, -1);

    for (int j = 0; j < 20; j++) begin
      bit e, sp;
      int pt, aa;
      logic [7:0] h;
      e  = 1'($urandom_range(0, 1));
      pt = int'($urandom_range(0, 2));
      h  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAST)) : -1;
      sp = 1'($urandom_range(0, 1));
      run_pkt(e, pt, h, aa, sp, -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
